elevator_scheduler: RTL and testbench

SCAN-style motion scheduler for a single elevator car. It latches floor requests into a pending bitmap, picks the travel direction, steps the car floor by floor with a travel timer, and opens the door at each requested floor with a dwell timer. An emergency stop overrides all motion. It drives the car status outputs (floor, direction, door) consumed by the display and motor logic.

---
 rtl/elevator_scheduler.sv | 240 ++++++++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
// ------------------
// Motion scheduler for one elevator car. It sweeps in one direction while
// there are requests ahead of the car, then reverses. Requests are latched
// into a pending bitmap. The car steps one floor each TRAVEL_CYCLES cycles
// and holds the door open for DOOR_CYCLES cycles at each requested floor.
// emergency_stop freezes the car with the door closed and locked.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous, active-high reset
//   req_valid      in   request strobe; req_floor is sampled when high
//   req_floor      in   requested floor index (out-of-range values ignored)
//   emergency_stop in   level-sensitive stop, overrides all motion
//   current_floor  out  registered car position
//   requests       out  registered pending-request bitmap
//   up/down/idle   out  state decodes (MOVE_UP / MOVE_DOWN / IDLE)
//   door           out  00 closed, 01 open, 10 closed-and-locked
//   arrived        out  one-cycle pulse when the car stops at a requested floor
//   state_dbg      out  raw FSM state encoding, for checkers and debug
//
// Handshake: there is no back-pressure. A request is accepted on every
// rising edge where req_valid is high, unless it is out of range, the car is
// in EMERG, emergency_stop is high, or it names the current floor while the
// door is open (that case restarts the door dwell instead).

module elevator_scheduler #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  emergency_stop,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] requests,
  output logic                  up,
  output logic                  down,
  output logic                  idle,
  output logic [1:0]            door,
  output logic                  arrived,
  output logic [2:0]            state_dbg
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [FLOOR_W:0]   NUM_FLOORS_L = (FLOOR_W + 1)'(NUM_FLOORS);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR    = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TW-1:0]      TRAVEL_LAST  = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST    = DW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MOVE_UP   = 3'd1,
    S_MOVE_DOWN = 3'd2,
    S_DOOR_OPEN = 3'd3,
    S_EMERG     = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [FLOOR_W-1:0]    floor_next;
  logic [NUM_FLOORS-1:0] requests_next;
  logic                  last_dir, last_dir_next;  // 1 = up, 0 = down
  logic [TW-1:0]         travel_cnt, travel_next;
  logic [DW-1:0]         door_cnt, door_next;
  logic                  arrived_next;

  // Floor masks: one-hot at a floor, and all floors strictly above/below it.
  function automatic logic [NUM_FLOORS-1:0] onehot_of(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) == f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
    return m;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
    return m;
  endfunction

  // Request acceptance, independent of the floor-specific door rule.
  logic                  req_accept;
  logic [NUM_FLOORS-1:0] req_mask;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic                  any_above, any_below, cur_pending;

  assign req_accept = req_valid && ({1'b0, req_floor} < NUM_FLOORS_L) &&
                      !emergency_stop && (state != S_EMERG);
  assign req_mask   = req_accept ? onehot_of(req_floor) : '0;
  assign cur_mask   = onehot_of(current_floor);
  assign any_above  = |(requests & above_of(current_floor));
  assign any_below  = |(requests & below_of(current_floor));
  assign cur_pending = |(requests & cur_mask);

  // Candidate position after one floor of travel, saturated at the ends.
  logic [FLOOR_W-1:0]    step_floor;
  logic [NUM_FLOORS-1:0] step_mask;
  logic [NUM_FLOORS-1:0] pending;   // latched requests plus this cycle's request
  logic                  ahead_after_step;

  always_comb begin
    step_floor = current_floor;
    if (state == S_MOVE_UP) begin
      if (current_floor != TOP_FLOOR) step_floor = current_floor + FLOOR_W'(1);
    end else if (state == S_MOVE_DOWN) begin
      if (current_floor != '0) step_floor = current_floor - FLOOR_W'(1);
    end
  end

  assign step_mask = onehot_of(step_floor);
  assign pending   = requests | req_mask;
  assign ahead_after_step = (state == S_MOVE_UP) ? |(pending & above_of(step_floor))
                                                 : |(pending & below_of(step_floor));

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      current_floor <= '0;
      requests      <= '0;
      last_dir      <= 1'b1;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      arrived       <= 1'b0;
    end else begin
      state         <= state_next;
      current_floor <= floor_next;
      requests      <= requests_next;
      last_dir      <= last_dir_next;
      travel_cnt    <= travel_next;
      door_cnt      <= door_next;
      arrived       <= arrived_next;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_next    = state;
    floor_next    = current_floor;
    requests_next = requests | req_mask;
    last_dir_next = last_dir;
    travel_next   = travel_cnt;
    door_next     = door_cnt;
    arrived_next  = 1'b0;

    unique case (state)
      S_IDLE: begin
        travel_next = '0;
        door_next   = '0;
        if (cur_pending) begin
          // Clearing wins over a same-cycle request for this floor: the door
          // is opening for it anyway.
          state_next    = S_DOOR_OPEN;
          requests_next = (requests | req_mask) & ~cur_mask;
          arrived_next  = 1'b1;
        end else if (any_above && (last_dir || !any_below)) begin
          state_next    = S_MOVE_UP;
          last_dir_next = 1'b1;
        end else if (any_below) begin
          state_next    = S_MOVE_DOWN;
          last_dir_next = 1'b0;
        end
      end

      S_MOVE_UP, S_MOVE_DOWN: begin
        if (travel_cnt == TRAVEL_LAST) begin
          travel_next = '0;
          floor_next  = step_floor;
          if (|(pending & step_mask)) begin
            state_next    = S_DOOR_OPEN;
            requests_next = pending & ~step_mask;
            arrived_next  = 1'b1;
          end else if (!ahead_after_step) begin
            state_next = S_IDLE;
          end
        end else begin
          travel_next = travel_cnt + TW'(1);
        end
      end

      S_DOOR_OPEN: begin
        travel_next = '0;
        if (|(req_mask & cur_mask)) begin
          // Someone pressed the current floor again: keep the door open for
          // a full dwell and do not record a new stop.
          requests_next = requests | (req_mask & ~cur_mask);
          door_next     = '0;
        end else if (door_cnt == DOOR_LAST) begin
          state_next = S_IDLE;
          door_next  = '0;
        end else begin
          door_next = door_cnt + DW'(1);
        end
      end

      S_EMERG: begin
        travel_next = '0;
        door_next   = '0;
        if (!emergency_stop) state_next = S_IDLE;
      end

      default: begin
        state_next  = S_IDLE;
        travel_next = '0;
        door_next   = '0;
      end
    endcase

    // Emergency overrides everything above: freeze position, bitmap and
    // sweep direction, and drop any partial travel or dwell.
    if (emergency_stop) begin
      state_next    = S_EMERG;
      floor_next    = current_floor;
      requests_next = requests;
      last_dir_next = last_dir;
      travel_next   = '0;
      door_next     = '0;
      arrived_next  = 1'b0;
    end
  end

  // Status outputs decode only registered state.
  assign up        = (state == S_MOVE_UP);
  assign down      = (state == S_MOVE_DOWN);
  assign idle      = (state == S_IDLE);
  assign door      = (state == S_EMERG)     ? 2'b10 :
                     (state == S_DOOR_OPEN) ? 2'b01 : 2'b00;
  assign state_dbg = state;

endmodule

// File: tb/tb_elevator_scheduler.sv
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int FW = 4;   // wide enough to express out-of-range floor 8

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_MOVE_UP = 3'd1;
  localparam logic [2:0] ST_EMERG   = 3'd4;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          emergency_stop;
  logic [FW-1:0] current_floor;
  logic [NF-1:0] requests;
  logic          up;
  logic          down;
  logic          idle;
  logic [1:0]    door;
  logic          arrived;
  logic [2:0]    state_dbg;

  elevator_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(4), .DOOR_CYCLES(6)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .emergency_stop(emergency_stop), .current_floor(current_floor),
    .requests(requests), .up(up), .down(down), .idle(idle), .door(door),
    .arrived(arrived), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected floor for each arrival pulse
  logic [FW-1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (arrived === 1'b1) begin
      if (exp_q.size() == 0) check("arrival_unexpected", 32'(arrived), 32'd0);
      else check("arrival_floor", 32'(current_floor), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic tick_until(input int n);
    while (cyc < n) tick();
  endtask

  // Drive one request for a single cycle.
  task automatic req_tick(input logic [FW-1:0] f, input bit expect_arrival);
    req_valid = 1'b1;
    req_floor = f;
    if (expect_arrival) exp_q.push_back(f);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_floor"}, 32'(current_floor), 32'd0);
    check({tag, "_requests"}, 32'(requests), 32'd0);
    check({tag, "_idle"}, 32'(idle), 32'd1);
    check({tag, "_up"}, 32'(up), 32'd0);
    check({tag, "_down"}, 32'(down), 32'd0);
    check({tag, "_door"}, 32'(door), 32'd0);
    check({tag, "_arrived"}, 32'(arrived), 32'd0);
    check({tag, "_state"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_floor = '0;
    emergency_stop = 1'b0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    cyc = 0;

    // Single request for floor 3
    req_tick(4'd3, 1'b1);                                   // edge 1
    check("t1_latched", 32'(requests), 32'h08);
    check("t1_idle_e1", 32'(idle), 32'd1);
    tick();                                                 // edge 2
    check("t1_move_up", 32'(state_dbg), 32'(ST_MOVE_UP));
    tick_until(5);
    check("t1_floor_e5", 32'(current_floor), 32'd0);
    tick();
    check("t1_floor_e6", 32'(current_floor), 32'd1);
    tick_until(10);
    check("t1_floor_e10", 32'(current_floor), 32'd2);
    tick_until(14);
    check("t1_floor_e14", 32'(current_floor), 32'd3);
    check("t1_door_open", 32'(door), 32'd1);
    check("t1_arrived", 32'(arrived), 32'd1);
    check("t1_cleared", 32'(requests), 32'h00);
    tick();
    check("t1_arrived_pulse", 32'(arrived), 32'd0);
    tick_until(19);
    check("t1_door_e19", 32'(door), 32'd1);
    tick();                                                 // edge 20
    check("t1_idle_e20", 32'(idle), 32'd1);
    check("t1_door_e20", 32'(door), 32'd0);

    // SCAN ordering: up to 6 first, then down to 1
    req_tick(4'd6, 1'b1);                                   // edge 21
    tick();
    check("t2_up", 32'(up), 32'd1);
    tick_until(26);
    check("t2_floor4", 32'(current_floor), 32'd4);
    req_tick(4'd1, 1'b1);                                   // edge 27
    check("t2_both_pending", 32'(requests), 32'h42);
    tick_until(30);
    check("t2_pass5_floor", 32'(current_floor), 32'd5);
    check("t2_pass5_up", 32'(up), 32'd1);
    check("t2_pass5_door", 32'(door), 32'd0);
    tick_until(34);
    check("t2_stop6_floor", 32'(current_floor), 32'd6);
    check("t2_stop6_door", 32'(door), 32'd1);
    tick_until(40);
    check("t2_idle_e40", 32'(idle), 32'd1);
    tick();
    check("t2_reverse_down", 32'(down), 32'd1);
    tick_until(57);
    check("t2_pass2_floor", 32'(current_floor), 32'd2);
    check("t2_pass2_down", 32'(down), 32'd1);
    tick_until(61);
    check("t2_stop1_floor", 32'(current_floor), 32'd1);
    check("t2_stop1_door", 32'(door), 32'd1);
    tick_until(67);
    check("t2_idle_e67", 32'(idle), 32'd1);

    // Request at the current floor, and a repeat mid-dwell
    req_tick(4'd2, 1'b1);                                   // edge 68
    tick();
    check("t3_up", 32'(up), 32'd1);
    tick_until(73);
    check("t3_at2", 32'(current_floor), 32'd2);
    tick_until(79);
    check("t3_idle_e79", 32'(idle), 32'd1);
    req_tick(4'd2, 1'b1);                                   // edge 80
    check("t3_latched_here", 32'(requests), 32'h04);
    check("t3_idle_e80", 32'(idle), 32'd1);
    tick();                                                 // edge 81
    check("t3_door_open", 32'(door), 32'd1);
    check("t3_cleared", 32'(requests), 32'h00);
    tick_until(84);
    req_tick(4'd2, 1'b0);                                   // edge 85
    check("t3_repeat_not_latched", 32'(requests), 32'h00);
    tick_until(87);
    check("t3_still_open_e87", 32'(door), 32'd1);
    tick_until(90);
    check("t3_still_open_e90", 32'(door), 32'd1);
    tick();
    check("t3_idle_e91", 32'(idle), 32'd1);
    check("t3_closed_e91", 32'(door), 32'd0);

    // Floor 0 request arriving the cycle the car reaches floor 0
    req_tick(4'd0, 1'b1);                                   // edge 92
    tick();
    check("t5_down", 32'(down), 32'd1);
    tick_until(97);
    check("t5_floor1", 32'(current_floor), 32'd1);
    tick_until(100);
    req_tick(4'd0, 1'b0);                                   // edge 101
    check("t5_floor0", 32'(current_floor), 32'd0);
    check("t5_door_open", 32'(door), 32'd1);
    check("t5_bit0_clear", 32'(requests), 32'h00);
    tick();
    check("t5_bit0_clear_e102", 32'(requests), 32'h00);
    tick_until(107);
    check("t5_idle", 32'(idle), 32'd1);

    // Emergency two cycles into MOVE_UP
    req_tick(4'd5, 1'b1);                                   // edge 108
    tick();
    check("t4_up", 32'(up), 32'd1);
    tick();                                                 // edge 110
    emergency_stop = 1'b1;
    tick();                                                 // edge 111
    check("t4_door_locked", 32'(door), 32'd2);
    check("t4_state", 32'(state_dbg), 32'(ST_EMERG));
    check("t4_up_low", 32'(up), 32'd0);
    check("t4_idle_low", 32'(idle), 32'd0);
    check("t4_floor_held", 32'(current_floor), 32'd0);
    check("t4_req_held", 32'(requests), 32'h20);
    req_tick(4'd7, 1'b0);                                   // edge 112
    check("t4_req_dropped", 32'(requests), 32'h20);
    check("t4_door_still_locked", 32'(door), 32'd2);
    tick();                                                 // edge 113
    emergency_stop = 1'b0;
    tick();                                                 // edge 114
    check("t4_release_idle", 32'(idle), 32'd1);
    check("t4_release_door", 32'(door), 32'd0);
    tick();                                                 // edge 115
    check("t4_reenter_up", 32'(up), 32'd1);
    tick_until(118);
    check("t4_no_partial_credit", 32'(current_floor), 32'd0);
    tick();
    check("t4_floor1", 32'(current_floor), 32'd1);
    tick_until(135);
    check("t4_stop5", 32'(current_floor), 32'd5);
    check("t4_stop5_door", 32'(door), 32'd1);
    tick_until(141);
    check("t4_idle", 32'(idle), 32'd1);

    // Out-of-range floor, then the top floor
    req_tick(4'd8, 1'b0);                                   // edge 142
    check("t5_oob_ignored", 32'(requests), 32'h00);
    tick();                                                 // edge 143
    check("t5_oob_idle", 32'(idle), 32'd1);
    req_tick(4'd7, 1'b1);                                   // edge 144
    check("t5_top_latched", 32'(requests), 32'h80);
    tick();
    check("t5_top_up", 32'(up), 32'd1);
    tick_until(153);
    check("t5_top_floor", 32'(current_floor), 32'd7);
    check("t5_top_door", 32'(door), 32'd1);
    tick_until(165);
    check("t5_no_wrap_floor", 32'(current_floor), 32'd7);
    check("t5_no_wrap_idle", 32'(idle), 32'd1);

    // Reset during MOVE_DOWN with emergency_stop high
    req_tick(4'd2, 1'b0);                                   // edge 166
    tick();                                                 // edge 167
    check("t6_down", 32'(down), 32'd1);
    tick();                                                 // edge 168
    rst = 1'b1;
    emergency_stop = 1'b1;
    tick();                                                 // edge 169
    check_reset("t6_reset");
    rst = 1'b0;
    emergency_stop = 1'b0;
    tick();
    check("t6_post_idle", 32'(idle), 32'd1);
    check("t6_post_floor", 32'(current_floor), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
